// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame-buffer constants, timing values and CPU FSM encoding
package vga_pkg;

  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;

  // 640x480@60 timing used by the vgaTiming block that drives this arbiter
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_PIXELS + H_FP + H_SYNC + H_BP;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_PIXELS + V_FP + V_SYNC + V_BP;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int FB_WORDS = H_PIXELS * V_PIXELS;

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/vga_pixel_addr.sv
// rtl/vga_pixel_addr.sv - linear frame-buffer address of the current pixel
module vga_pixel_addr
  import vga_pkg::*;
(
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  output logic [ADDR_W-1:0] pix_addr
);

  logic [ADDR_W-1:0] v_ext;
  logic [ADDR_W-1:0] h_ext;

  assign v_ext = {{(ADDR_W-10){1'b0}}, vCount};
  assign h_ext = {{(ADDR_W-10){1'b0}}, hCount};

  // vCount*640 = vCount*512 + vCount*128
  assign pix_addr = (v_ext << 9) + (v_ext << 7) + h_ext;

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - time-slots one frame-buffer RAM between VGA fetch and a CPU port
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk50MHz,
  input  logic              clr,
  input  logic              vgaClk,
  input  logic              bright,
  input  logic              hSync,
  input  logic              vSync,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              out_hSync,
  output logic              out_vSync,
  output logic              out_bright
);

  logic [ADDR_W-1:0] pix_addr;
  logic              video_slot;
  logic              cpu_issue;
  logic              addr_err;

  cpu_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic              slot_q;
  logic              blank_q;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [1:0]        hs_q, vs_q, br_q;

  vga_pixel_addr u_pixel_addr (
    .hCount   (hCount),
    .vCount   (vCount),
    .pix_addr (pix_addr)
  );

  assign video_slot = vgaClk & bright;
  assign addr_err   = (cpu_addr >= FB_LIMIT);
  assign cpu_issue  = (state_q == ST_IDLE) & cpu_req & ~video_slot;

  assign mem_addr  = video_slot ? pix_addr : cpu_addr;
  assign mem_we    = cpu_issue & cpu_we & ~addr_err;
  assign mem_wdata = cpu_wdata;

  // Gating with clr drops the completion of an access caught by reset
  assign cpu_ack   = (state_q == ST_BUSY) & ~clr;
  assign cpu_rdata = (cpu_ack & rd_q) ? mem_rdata : '0;
  assign cpu_err   = cpu_ack & err_q;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_issue) begin
          state_d = ST_BUSY;
          rd_d    = ~cpu_we & ~addr_err;
          err_d   = addr_err;
        end
      end
      ST_BUSY: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM data for a video slot lands one cycle later; blank pixels force black
  always_comb begin
    pix_d = pix_q;
    if (slot_q) begin
      pix_d = mem_rdata;
    end else if (blank_q) begin
      pix_d = '0;
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (clr) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      slot_q  <= 1'b0;
      blank_q <= 1'b0;
      pix_q   <= '0;
      hs_q    <= 2'b11;
      vs_q    <= 2'b11;
      br_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      slot_q  <= video_slot;
      blank_q <= vgaClk & ~bright;
      pix_q   <= pix_d;
      hs_q    <= {hs_q[0], hSync};
      vs_q    <= {vs_q[0], vSync};
      br_q    <= {br_q[0], bright};
    end
  end

  assign pix_data   = pix_q;
  assign out_hSync  = hs_q[1];
  assign out_vSync  = vs_q[1];
  assign out_bright = br_q[1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        clk50MHz = 1'b0;
  logic        clr;
  logic        vgaClk;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pix_data;
  logic        out_hSync;
  logic        out_vSync;
  logic        out_bright;

  logic [7:0]  ram [0:307199];
  int          passed = 0;
  int          total  = 0;
  int          acks;

  vga_fb_arbiter dut (
    .clk50MHz   (clk50MHz),
    .clr        (clr),
    .vgaClk     (vgaClk),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync),
    .hCount     (hCount),
    .vCount     (vCount),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .out_hSync  (out_hSync),
    .out_vSync  (out_vSync),
    .out_bright (out_bright)
  );

  always #5 clk50MHz = ~clk50MHz;

  // Synchronous-read, read-first single-port RAM
  always @(posedge clk50MHz) begin
    if (mem_addr < 19'd307200) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end else begin
      mem_rdata <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  // One 25MHz pixel: video slot then CPU slot; checks the pixel fetched two cycles earlier
  task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic [18:0] exp_addr,
                       input logic [7:0] prev_pix, input logic exp_br);
    vgaClk = 1'b1; bright = 1'b1; hCount = h; vCount = v;
    #1;
    chk("pix_addr", mem_addr, exp_addr);
    chk("pix_we", mem_we, 1'b0);
    chk("pix_data", pix_data, prev_pix);
    chk("pix_bright", out_bright, exp_br);
    tick();
    vgaClk = 1'b0;
    #1;
    chk("pix_hold", pix_data, prev_pix);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 307200; i++) ram[i] = i[7:0];

    clr = 1'b1; vgaClk = 1'b0; bright = 1'b0; hSync = 1'b1; vSync = 1'b1;
    hCount = '0; vCount = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_ack", cpu_ack, 1'b0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_pix", pix_data, 8'h00);
    chk("rst_bright", out_bright, 1'b0);
    chk("rst_hsync", out_hSync, 1'b1);
    chk("rst_vsync", out_vSync, 1'b1);
    clr = 1'b0;
    tick();

    // Address generation and pixel alignment
    pixel(10'd0,   10'd0,   19'd0,      8'h00, 1'b0);
    pixel(10'd5,   10'd0,   19'd5,      8'h00, 1'b1);
    pixel(10'd639, 10'd0,   19'd639,    8'h05, 1'b1);
    pixel(10'd0,   10'd1,   19'd640,    8'h7F, 1'b1);
    pixel(10'd639, 10'd479, 19'd307199, 8'h80, 1'b1);
    vgaClk = 1'b1; bright = 1'b0;
    #1 chk("blank_pix0", pix_data, 8'hFF);
    tick(); vgaClk = 1'b0;
    #1 chk("blank_pix1", pix_data, 8'hFF);
    tick();
    #1 chk("blank_pix2", pix_data, 8'h00);
    chk("blank_bright", out_bright, 1'b0);
    tick();

    // Blanking write then read of address 1000
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd1000; cpu_wdata = 8'hA5;
    #1;
    chk("wr_issue_we", mem_we, 1'b1);
    chk("wr_issue_addr", mem_addr, 19'd1000);
    chk("wr_issue_data", mem_wdata, 8'hA5);
    chk("wr_issue_ack", cpu_ack, 1'b0);
    tick();
    chk("wr_ack", cpu_ack, 1'b1);
    chk("wr_rdata", cpu_rdata, 8'h00);
    chk("wr_err", cpu_err, 1'b0);
    cpu_req = 1'b0;
    tick();
    chk("wr_ack_gone", cpu_ack, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd1000;
    #1 chk("rd_issue_we", mem_we, 1'b0);
    tick();
    chk("rd_ack", cpu_ack, 1'b1);
    chk("rd_rdata", cpu_rdata, 8'hA5);
    cpu_req = 1'b0;
    tick();

    // Out of range write, then last valid address read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd307200; cpu_wdata = 8'h33;
    #1 chk("oor_we", mem_we, 1'b0);
    tick();
    chk("oor_we_busy", mem_we, 1'b0);
    chk("oor_ack", cpu_ack, 1'b1);
    chk("oor_err", cpu_err, 1'b1);
    chk("oor_rdata", cpu_rdata, 8'h00);
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd307199;
    tick();
    chk("last_ack", cpu_ack, 1'b1);
    chk("last_err", cpu_err, 1'b0);
    chk("last_rdata", cpu_rdata, 8'hFF);
    cpu_req = 1'b0;
    tick();

    // Continuous requests during blanking
    acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd200;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cpu_ack) begin
        acks++;
        chk("cont_rdata", cpu_rdata, 8'hC8);
      end
      tick();
    end
    chk("cont_acks", acks, 5);
    cpu_req = 1'b0;
    tick();

    // Contention: request raised in a video slot
    vgaClk = 1'b1; bright = 1'b1; hCount = 10'd10; vCount = 10'd2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd50;
    #1;
    chk("cont_vid_addr", mem_addr, 19'd1290);
    chk("cont_vid_ack", cpu_ack, 1'b0);
    tick();
    vgaClk = 1'b0;
    #1;
    chk("cont_cpu_addr", mem_addr, 19'd50);
    chk("cont_cpu_ack", cpu_ack, 1'b0);
    tick();
    vgaClk = 1'b1; hCount = 10'd11;
    #1;
    chk("cont_ack", cpu_ack, 1'b1);
    chk("cont_rd", cpu_rdata, 8'h32);
    chk("cont_vid_addr2", mem_addr, 19'd1291);
    chk("cont_pix0", pix_data, 8'h0A);
    cpu_req = 1'b0;
    tick();
    vgaClk = 1'b0;
    #1 chk("cont_pix0_hold", pix_data, 8'h0A);
    tick();
    vgaClk = 1'b1; hCount = 10'd12;
    #1 chk("cont_pix1", pix_data, 8'h0B);
    tick();
    vgaClk = 1'b0; bright = 1'b0;
    tick();

    // Sync delay, then reset during a BUSY cycle
    hSync = 1'b0; vSync = 1'b0;
    #1 chk("hs_d0", out_hSync, 1'b1);
    tick();
    chk("hs_d1", out_hSync, 1'b1);
    tick();
    chk("hs_d2", out_hSync, 1'b0);
    chk("vs_d2", out_vSync, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd2000; cpu_wdata = 8'h55;
    tick();
    clr = 1'b1; cpu_req = 1'b0;
    #1 chk("rst_busy_ack", cpu_ack, 1'b0);
    tick();
    clr = 1'b0;
    #1;
    chk("rst2_ack", cpu_ack, 1'b0);
    chk("rst2_hsync", out_hSync, 1'b1);
    chk("rst2_pix", pix_data, 8'h00);
    chk("rst2_bright", out_bright, 1'b0);
    tick();
    chk("rst3_ack", cpu_ack, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port, synchronous-read frame-buffer RAM between two requesters: the VGA pixel fetch, driven by the vgaTiming outputs, and a CPU/draw-engine port using a req/ack handshake.
- Time-slots the RAM on clk50MHz: the video fetch owns the phase where vgaClk=1 during active display; the CPU gets every other slot.
- Re-times hSync/vSync/bright so they stay aligned with the fetched pixel data going to the DAC.

Parameters:
- H_PIXELS, 640, active pixels per line
- V_PIXELS, 480, active lines per frame
- ADDR_W, 19, frame-buffer word address width
- DATA_W, 8, pixel/word width
- FB_WORDS, 307200, valid frame-buffer words (H_PIXELS*V_PIXELS)

Ports:
- clk50MHz  in  1  system clock
- clr  in  1  synchronous active-high reset
- vgaClk  in  1  25MHz phase enable from timing block
- bright  in  1  active-display flag from timing
- hSync, vSync  in  1 each  raw syncs from timing
- hCount, vCount  in  10 each  pixel/line position from timing
- cpu_req  in  1  CPU request; held with fields stable until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle
- cpu_err  out  1  pulses with cpu_ack when cpu_addr >= FB_WORDS
- mem_addr  out  ADDR_W  RAM address (combinational from slot owner)
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- pix_data  out  DATA_W  pixel to DAC
- out_hSync, out_vSync, out_bright  out  1 each  syncs/bright delayed to match pix_data

Behaviour:
- **Reset** (clr=1 at a clock edge):
  - cpu_ack=0, cpu_rdata=0, cpu_err=0, pix_data=0, out_bright=0, out_hSync=1, out_vSync=1.
  - CPU FSM goes to IDLE and the delay pipeline is cleared to these values.
  - A request in flight when reset occurs is dropped: no ack is ever issued for it.
- **Slot rule, each cycle:**
  - Video slot = vgaClk=1 and bright=1. mem_we=0; mem_addr = vCount*H_PIXELS + hCount, 19-bit shift-add, no wrap.
  - Every other cycle is a CPU slot.
  - The video slot always wins; a CPU request never preempts it.
- **CPU FSM states IDLE, BUSY:**
  - IDLE → BUSY: cpu_req=1 in a CPU slot. The access issues that cycle:
    - mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
    - If cpu_addr >= FB_WORDS, mem_we is forced 0 and the access is flagged as an error.
  - BUSY → IDLE: always on the next cycle. That cycle pulses cpu_ack=1.
    - cpu_rdata = mem_rdata for reads, or 0 for errors and writes.
    - cpu_err=1 for an out-of-range access.
  - No issue in the BUSY cycle. Back-to-back CPU accesses are therefore at most one per 2 cycles.
  - A requester keeping cpu_req high through cpu_ack is treated as presenting a new request.
- **Latency:**
  - CPU: 2 cycles minimum (issue + ack).
  - During active display the worst case is 3 cycles, since the request can wait one video slot.
  - During blanking, requests issue on the first cycle cpu_req is seen in IDLE.
- **Pixel path:**
  - The cycle after a video slot, pix_data <= mem_rdata.
  - The cycle after a vgaClk=1 cycle with bright=0, pix_data <= 0.
  - pix_data holds otherwise, so each pixel is stable for 2 cycles.
  - out_hSync/out_vSync/out_bright = inputs delayed by exactly 2 clk50MHz cycles via shift registers, aligned with pix_data.
- **Boundaries:**
  - Pixel (639,479) → address 307199.
  - cpu_addr = 307199 is valid; 307200 raises cpu_err.
  - cpu_req rising in the video slot issues in the following CPU slot.
  - A CPU write to the address being displayed takes effect for subsequent fetches only; no forwarding.

Decomposition:
- Shared package vga_pkg: H_PIXELS, V_PIXELS, the H_/V_ timing constants used by vgaTiming, FB_WORDS, ADDR_W, DATA_W, and CPU FSM state encodings.
- One sub-module, vga_pixel_addr: combinational vCount*640+hCount computed as (vCount<<9)+(vCount<<7)+hCount, 19-bit output.

Test Plan:
- **Address generation:** clr pulse, then run the timing model for a full frame. Pixel (0,0) → mem_addr 0; (639,0) → 639; (0,1) → 640; (639,479) → 307199. pix_data follows RAM preload pattern addr[7:0] with 2-cycle alignment to out_bright.
- **Blanking access:** CPU write 0xA5 to 1000 during vertical blanking issues the same cycle; cpu_ack exactly 1 cycle later. A read of 1000 then returns cpu_rdata=0xA5 with cpu_ack.
- **Contention:** cpu_req asserted in a video slot during active display. mem_addr equals the pixel address that cycle, the CPU access issues next cycle, cpu_ack arrives 3 cycles after req, and the pixel stream shows no gaps.
- **Out of range:** write to 307200 → mem_we never asserted; cpu_ack=1 with cpu_err=1 and cpu_rdata=0.
- **Continuous requests:** cpu_req held high for 10 reads during blanking → 5 acks in 10 cycles, one every 2 cycles.
- **Reset mid-operation:** clr asserted in the BUSY cycle → no cpu_ack. Next cycle outputs are at reset values (out_hSync=1, pix_data=0, FSM IDLE).
